// File: rtl/aes_inv_key_schedule.sv
// AES-128 inverse key expansion: regenerates round keys NUM_ROUNDS..0, one per rk_valid/rk_ready handshake.
// Optional feature: define AES_INV_KS_ZEROIZE_EN to clear the key register once round 0 is consumed.
module aes_inv_key_schedule #(
  parameter int unsigned NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] last_key,
  output logic [127:0] rk,
  output logic [3:0]   rk_round,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic         busy,
  output logic         done
);
  localparam int unsigned KEY_W  = 128;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned RND_W  = 4;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  typedef enum logic {IDLE, EMIT} state_t;

  function automatic logic [7:0] rcon(input logic [RND_W-1:0] n);
    case (n)
      4'd0:    rcon = 8'h01;
      4'd1:    rcon = 8'h02;
      4'd2:    rcon = 8'h04;
      4'd3:    rcon = 8'h08;
      4'd4:    rcon = 8'h10;
      4'd5:    rcon = 8'h20;
      4'd6:    rcon = 8'h40;
      4'd7:    rcon = 8'h80;
      4'd8:    rcon = 8'h1b;
      4'd9:    rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  state_t            state;
  logic [WORD_W-1:0] w0, w1, w2, w3, rot, sub;
  logic [KEY_W-1:0]  prev_key;

  // One backward step of the key expansion, taken from the key currently on rk.
  always_comb begin
    w3       = rk[127:96] ^ rk[95:64];
    w2       = rk[95:64]  ^ rk[63:32];
    w1       = rk[63:32]  ^ rk[31:0];
    rot      = {w3[7:0], w3[31:8]};
    sub      = {SBOX[rot[31:24]], SBOX[rot[23:16]], SBOX[rot[15:8]], SBOX[rot[7:0]]};
    w0       = rk[31:0] ^ sub ^ {24'h0, rcon(rk_round - RND_W'(1))};
    prev_key = {w3, w2, w1, w0};
  end

  // rk doubles as the key register, so the emitted key is always the working key.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rk       <= '0;
      rk_round <= '0;
      rk_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            rk       <= last_key;
            rk_round <= RND_W'(NUM_ROUNDS);
            rk_valid <= 1'b1;
            busy     <= 1'b1;
            state    <= EMIT;
          end
        end
        EMIT: begin
          if (rk_valid && rk_ready) begin
            if (rk_round != '0) begin
              rk       <= prev_key;
              rk_round <= rk_round - RND_W'(1);
            end else begin
              state    <= IDLE;
              rk_valid <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
`ifdef AES_INV_KS_ZEROIZE_EN
              rk       <= '0;
`else
              rk       <= rk;
`endif
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/aes_inv_key_schedule.md
# aes_inv_key_schedule

Iterative AES-128 inverse key expansion for the decryption datapath. It takes the final (round-NUM_ROUNDS) round key and regenerates earlier round keys one per handshake, in descending order, down to round 0 (the cipher key). The round-key byte packing matches the forward key schedule, so the inverse cipher can consume the keys directly in decryption order.

## Interface
- NUM_ROUNDS, 10, index of the input key; legal range 1..10; Rcon index for a step from round r is r-1.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  load `last_key` and begin; sampled only in IDLE.
- last_key  in  128  round-NUM_ROUNDS key. Byte k is at [8k+7:8k]. Word j is at [32j+31:32j].
- rk  out  128  current round key, same packing; valid while `rk_valid`=1.
- rk_round  out  4  round index of `rk`.
- rk_valid  out  1  `rk` and `rk_round` are valid.
- rk_ready  in  1  consumer accepts `rk` when `rk_valid`&&`rk_ready`.
- busy  out  1  high in EMIT.
- done  out  1  one-cycle pulse after round 0 is accepted.

## Operation
- States: IDLE and EMIT.
- Reset values: state=IDLE, rk=0, rk_round=0, rk_valid=0, busy=0, done=0.
- IDLE:
  - If `start`=1: key_reg<=last_key, rk_round<=NUM_ROUNDS, go to EMIT.
  - `start` is ignored in every other state.
- EMIT:
  - rk_valid=1, busy=1. `rk` is driven from key_reg.
  - `rk` and `rk_round` stay stable until the handshake.
  - On handshake with rk_round>0: key_reg<=prev(key_reg, rk_round-1), rk_round decrements, stay in EMIT.
  - On handshake with rk_round==0: go to IDLE and pulse `done`.
- prev(w', n), with w'0..w'3 the current words:
  - w3=w'3^w'2, w2=w'2^w'1, w1=w'1^w'0.
  - w0=w'0^SubWord(RotWord(w3))^Rcon[n].
  - RotWord(x)={x[7:0],x[31:8]}.
  - SubWord applies the forward AES S-box to each byte.
  - Rcon[0..9]=01,02,04,08,10,20,40,80,1b,36, applied to byte 0 (bits [7:0]) only.
- The step logic is purely combinational: four S-box lookups plus XORs, with no extra pipeline stage.
- Reset mid-operation: the state machine returns to IDLE immediately and all outputs go to their reset values. No `done` pulse.

## Timing
- `start` is accepted at edge T. `rk_valid`=1 with round NUM_ROUNDS from T+1.
- With `rk_ready` held high, one key per cycle: round r is valid at T+1+(NUM_ROUNDS-r).
- The round-0 handshake at edge E gives rk_valid=0, busy=0, done=1 in E..E+1, then done=0.
- `start` in the cycle `done`=1 is accepted (state is IDLE).
- `rk_ready` low stalls indefinitely with no state change.
- `rk_ready` is don't-care while `rk_valid`=0.

## Configuration
- AES_INV_KS_ZEROIZE_EN:
  - Defined: on the round-0 handshake, key_reg and `rk` are cleared to 0 together with the IDLE transition.
  - Undefined: key_reg and `rk` keep the round-0 key in IDLE until the next `start` or reset.

## Test plan
- FIPS-197 A.1 sweep:
  - Stimulus: NUM_ROUNDS=10, last_key=128'ha60c63b6c80c3fe18925eec9a8f914d0, `start` pulse, rk_ready=1.
  - Required: round 10 equals last_key; round 9=128'h6e005c574129d12821dcfa19f36677ac; round 0=128'h3c4fcf098815f7aba6d2ae2816157e2b. Keys on 11 consecutive cycles; `done` one cycle after round 0.
- Backpressure:
  - Stimulus: same vector, `rk_ready` random (~30%).
  - Required: same 11 keys in order. `rk`/`rk_round` stable while stalled; no skipped or duplicated round.
- Start while busy:
  - Stimulus: `start` with last_key=0 asserted during round 5.
  - Required: ignored; the sequence completes with the original values.
- Reset mid-run:
  - Stimulus: rst_n=0 asynchronously at round 4.
  - Required: rk_valid=0, busy=0, rk=0 without a clock edge; no `done`. A fresh `start` afterwards reproduces the A.1 sequence.
- Zeroize:
  - With AES_INV_KS_ZEROIZE_EN defined: rk=0 the cycle after the round-0 handshake.
  - Without it: rk=128'h3c4fcf098815f7aba6d2ae2816157e2b persists in IDLE.
- Short schedule:
  - Stimulus: NUM_ROUNDS=1, last_key = round-1 key 128'h05766c2a3939a323b12c548817fefaa0.
  - Required: two keys (round 1 then round 0=128'h3c4fcf098815f7aba6d2ae2816157e2b), then `done`.
